spi_sclk_gen: RTL and testbench

SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

---
 rtl/spi_sclk_gen_pkg.sv | 26 ++
 rtl/spi_sclk_gen_if.sv | 42 ++++
 rtl/spi_halfper_cnt.sv | 48 ++++
 rtl/spi_sclk_gen.sv | 151 +++++++++++++++
 tb/tb_spi_sclk_gen.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/spi_sclk_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_sclk_gen_pkg
// Purpose  : Shared definitions for the SPI SCLK generator slice: FSM state
//            encoding, default widths and the chip-select idle level.
// Ports    : none (package)
// Config   : SPI_SCLK_CS_GUARD_EN (consumed by spi_sclk_gen) enables the
//            LEAD/TRAIL chip-select guard states.
// Revision : 1.0 - initial release
// ============================================================================
package spi_sclk_gen_pkg;

  localparam int   DIV_W_DEF   = 8;
  localparam int   NBITS_W_DEF = 5;
  localparam logic CS_IDLE     = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_TRAIL  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage : spi_sclk_gen_pkg
`default_nettype wire

// File: rtl/spi_sclk_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_sclk_gen_if
// Purpose  : Bundles the request/configuration inputs and the clock/status
//            outputs of spi_sclk_gen.
// Ports    : i_start, i_cpol, i_div[DIV_W], i_nbits[NBITS_W] (requester side)
//            o_sclk, o_lead_edge, o_trail_edge, o_cs_n, o_busy, o_done
//            (generator side)
// Modports : master - drives requests, observes outputs
//            slave  - the generator itself
// Revision : 1.0 - initial release
// ============================================================================
interface spi_sclk_gen_if
  import spi_sclk_gen_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int NBITS_W = NBITS_W_DEF
) ();

  logic               i_start;
  logic               i_cpol;
  logic [DIV_W-1:0]   i_div;
  logic [NBITS_W-1:0] i_nbits;
  logic               o_sclk;
  logic               o_lead_edge;
  logic               o_trail_edge;
  logic               o_cs_n;
  logic               o_busy;
  logic               o_done;

  modport master (
    output i_start, i_cpol, i_div, i_nbits,
    input  o_sclk, o_lead_edge, o_trail_edge, o_cs_n, o_busy, o_done
  );

  modport slave (
    input  i_start, i_cpol, i_div, i_nbits,
    output o_sclk, o_lead_edge, o_trail_edge, o_cs_n, o_busy, o_done
  );

endinterface : spi_sclk_gen_if
`default_nettype wire

// File: rtl/spi_halfper_cnt.sv
`default_nettype none
// ============================================================================
// Module   : spi_halfper_cnt
// Purpose  : SCLK half-period counter. Counts 0..i_limit while enabled and
//            pulses o_tick on the terminal count, wrapping back to 0.
// Ports    : i_clk, i_rst_n      - clock, async active-low reset
//            i_load              - clear the count to 0 (has priority)
//            i_en                - count enable
//            i_limit[DIV_W]      - terminal count (half-period minus one)
//            o_tick              - terminal-count pulse
// Revision : 1.0 - initial release
// ============================================================================
module spi_halfper_cnt
  import spi_sclk_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_limit,
  output logic             o_tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign o_tick = i_en && !i_load && (cnt_q == i_limit);

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = o_tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : spi_halfper_cnt
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_sclk_gen
// Purpose  : SPI serial-clock generator. On an accepted start it latches
//            CPOL / divider / bit count, asserts chip select and produces
//            2*nbits SCLK transitions, each (div+1) i_clk cycles apart, with
//            one-cycle lead/trail edge strobes and a completion pulse.
// Ports    : i_clk, i_rst_n      - clock, async active-low reset
//            bus (slave modport) - i_start, i_cpol, i_div, i_nbits in;
//                                  o_sclk, o_lead_edge, o_trail_edge,
//                                  o_cs_n, o_busy, o_done out
// Config   : SPI_SCLK_CS_GUARD_EN - when defined, a (div+1)-cycle LEAD state
//            precedes and a TRAIL state follows the SCLK burst, holding chip
//            select low around it. Undefined: IDLE->ACTIVE->DONE.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sclk_gen
  import spi_sclk_gen_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int NBITS_W = NBITS_W_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  spi_sclk_gen_if.slave bus
);

  state_e             state_q, state_d;
  logic               cpol_q, cpol_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [NBITS_W-1:0] nbits_q, nbits_d;
  // One extra bit so that 2*(2^NBITS_W-1) toggles fit.
  logic [NBITS_W:0]   tog_q, tog_d;
  logic               sclk_q, sclk_d;
  logic               lead_q, lead_d;
  logic               trail_q, trail_d;

  logic               w_busy;
  logic               w_tick;
  logic [NBITS_W:0]   w_tog_inc;
  logic [NBITS_W:0]   w_tog_tgt;

  assign w_busy    = (state_q == ST_LEAD) || (state_q == ST_ACTIVE) ||
                     (state_q == ST_TRAIL);
  assign w_tog_inc = tog_q + 1'b1;
  assign w_tog_tgt = {nbits_q, 1'b0};

  // The counter runs through LEAD, ACTIVE and TRAIL back to back; each of
  // those phases is a whole number of half-periods, so every state entry
  // coincides with a wrap to zero.
  spi_halfper_cnt #(
    .DIV_W (DIV_W)
  ) u_halfper_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (!w_busy),
    .i_en    (w_busy),
    .i_limit (div_q),
    .o_tick  (w_tick)
  );

  always_comb begin
    state_d = state_q;
    cpol_d  = cpol_q;
    div_d   = div_q;
    nbits_d = nbits_q;
    tog_d   = tog_q;
    sclk_d  = sclk_q;
    lead_d  = 1'b0;
    trail_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sclk_d = bus.i_cpol;
        tog_d  = '0;
        if (bus.i_start && (bus.i_nbits != '0)) begin
          cpol_d  = bus.i_cpol;
          div_d   = bus.i_div;
          nbits_d = bus.i_nbits;
`ifdef SPI_SCLK_CS_GUARD_EN
          state_d = ST_LEAD;
`else
          state_d = ST_ACTIVE;
`endif
        end
      end
`ifdef SPI_SCLK_CS_GUARD_EN
      ST_LEAD: begin
        if (w_tick) state_d = ST_ACTIVE;
      end
`endif
      ST_ACTIVE: begin
        if (w_tick) begin
          sclk_d  = ~sclk_q;
          // Leaving the idle level is a lead edge, returning is a trail edge.
          lead_d  = (sclk_q == cpol_q);
          trail_d = (sclk_q != cpol_q);
          tog_d   = w_tog_inc;
          if (w_tog_inc == w_tog_tgt) begin
`ifdef SPI_SCLK_CS_GUARD_EN
            state_d = ST_TRAIL;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef SPI_SCLK_CS_GUARD_EN
      ST_TRAIL: begin
        if (w_tick) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cpol_q  <= 1'b0;
      div_q   <= '0;
      nbits_q <= '0;
      tog_q   <= '0;
      sclk_q  <= 1'b0;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cpol_q  <= cpol_d;
      div_q   <= div_d;
      nbits_q <= nbits_d;
      tog_q   <= tog_d;
      sclk_q  <= sclk_d;
      lead_q  <= lead_d;
      trail_q <= trail_d;
    end
  end

  assign bus.o_sclk       = sclk_q;
  assign bus.o_lead_edge  = lead_q;
  assign bus.o_trail_edge = trail_q;
  assign bus.o_busy       = w_busy;
  assign bus.o_done       = (state_q == ST_DONE);
  assign bus.o_cs_n       = w_busy ? ~CS_IDLE : CS_IDLE;

endmodule : spi_sclk_gen
`default_nettype wire

// File: tb/tb_spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_sclk_gen
// Purpose  : Self-checking bench for spi_sclk_gen. Expected per-cycle output
//            vectors {sclk, cs_n, busy, done, lead, trail} are computed from
//            the transfer timing rules by arithmetic on the cycle index.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_sclk_gen;

  localparam int DIV_W   = 8;
  localparam int NBITS_W = 5;
`ifdef SPI_SCLK_CS_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  spi_sclk_gen_if #(.DIV_W(DIV_W), .NBITS_W(NBITS_W)) bus ();

  spi_sclk_gen #(.DIV_W(DIV_W), .NBITS_W(NBITS_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] obs();
    return {bus.o_sclk, bus.o_cs_n, bus.o_busy, bus.o_done,
            bus.o_lead_edge, bus.o_trail_edge};
  endfunction

  // p = number of clock edges since the start-sample edge (p=0: first cycle).
  function automatic logic [5:0] exp_vec(input int p, input bit cpol,
                                         input int div, input int n);
    int  d, l, a, t, j;
    bit  sclk, busy, done, pulse;
    d     = div + 1;
    l     = GUARD ? d : 0;
    a     = 2 * n * d;
    t     = p - l;
    busy  = (p < 2 * l + a);
    done  = (p == 2 * l + a);
    sclk  = cpol;
    pulse = 1'b0;
    j     = 0;
    if (t >= 0) begin
      j = t / d;
      if (t < a) sclk = cpol ^ j[0];
      pulse = (t >= d) && (t % d == 0) && (j <= 2 * n);
    end
    return {sclk, !busy, busy, done, pulse && j[0], pulse && !j[0]};
  endfunction

  task automatic check(input string tag, input logic [5:0] o,
                       input logic [5:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Runs one transfer from the current IDLE cycle. disturb: randomise all
  // inputs while busy; hold: leave i_start high at the end (back-to-back).
  task automatic run_xfer(input bit cpol, input int div, input int n,
                          input bit disturb, input bit hold, input string tag);
    int d, tot, last;
    d    = div + 1;
    tot  = 2 * (GUARD ? d : 0) + 2 * n * d + 1;
    last = hold ? tot + 1 : tot + 2;
    bus.i_start = 1'b1;
    bus.i_cpol  = cpol;
    bus.i_div   = DIV_W'(div);
    bus.i_nbits = NBITS_W'(n);
    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      #1;
      if (k <= tot)
        check($sformatf("%s k=%0d", tag, k), obs(), exp_vec(k - 1, cpol, div, n));
      else
        check($sformatf("%s idle k=%0d", tag, k), obs(), {cpol, 5'b10000});
      if (k < tot) begin
        if (disturb) begin
          bus.i_start = 1'($urandom_range(0, 1));
          bus.i_cpol  = 1'($urandom_range(0, 1));
          bus.i_div   = DIV_W'($urandom);
          bus.i_nbits = NBITS_W'($urandom);
        end else begin
          bus.i_start = hold;
        end
      end else begin
        bus.i_start = hold;
        bus.i_cpol  = cpol;
        bus.i_div   = DIV_W'(div);
        bus.i_nbits = NBITS_W'(n);
      end
    end
  endtask

  initial begin
    int cp, dv, nb, l;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_cpol  = 1'b1;
    bus.i_div   = '0;
    bus.i_nbits = '0;

    // Reset state (i_cpol=1 must not leak into sclk while in reset).
    #2;
    check("reset", obs(), 6'b010000);
    @(posedge clk);
    #1;
    check("reset_clk", obs(), 6'b010000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_follow_cpol", obs(), 6'b110000);

    // Directed cases, boundaries and mid-transfer disturbance.
    run_xfer(1'b1, 0, 1, 1'b0, 1'b0, "short");
    run_xfer(1'b0, 1, 8, 1'b0, 1'b0, "long");
    run_xfer(1'b1, 0, 31, 1'b0, 1'b0, "nbits_max");
    run_xfer(1'b0, 255, 1, 1'b0, 1'b0, "div_max");
    run_xfer(1'b0, 2, 3, 1'b1, 1'b0, "disturb");

    // nbits=0 start must be ignored.
    bus.i_start = 1'b1;
    bus.i_cpol  = 1'b0;
    bus.i_div   = 8'd1;
    bus.i_nbits = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("nbits0 k=%0d", k), obs(), 6'b010000);
    end
    bus.i_start = 1'b0;

    // Randomised transfers with inputs scrambled while busy.
    for (int r = 0; r < 6; r++) begin
      cp = int'($urandom_range(0, 1));
      dv = int'($urandom_range(0, 3));
      nb = int'($urandom_range(1, 6));
      run_xfer(cp[0], dv, nb, 1'b1, 1'b0, $sformatf("rand%0d", r));
    end

    // Back-to-back with i_start held high.
    run_xfer(1'b1, 1, 2, 1'b0, 1'b1, "b2b_a");
    run_xfer(1'b0, 0, 3, 1'b0, 1'b0, "b2b_b");

    // Reset during ACTIVE aborts immediately.
    l = GUARD ? 3 : 0;
    bus.i_start = 1'b1;
    bus.i_cpol  = 1'b1;
    bus.i_div   = 8'd2;
    bus.i_nbits = 5'd3;
    for (int k = 1; k <= l + 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("pre_rst k=%0d", k), obs(), exp_vec(k - 1, 1'b1, 2, 3));
      bus.i_start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("rst_async", obs(), 6'b010000);
    @(posedge clk);
    #1;
    check("rst_hold", obs(), 6'b010000);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_idle k=%0d", k), obs(), 6'b110000);
    end
    run_xfer(1'b0, 1, 4, 1'b0, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_spi_sclk_gen
`default_nettype wire
